decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined LEGv8 instruction-decode stage: sits between the IF/ID and ID/EX boundaries of the pipelined core.
- Parses the instruction, generates control, reads a parametrised register file and sign-extends the immediate.
- Registers all results into an ID/EX output register with valid/ready handshakes on both sides.
- Detects load-use hazards and inserts a one-cycle bubble.

Parameters:
- WORD, 64, register and datapath width in bits.
- NREG, 32, number of architectural registers; index NREG-1 is XZR (reads 0, writes ignored). Address width is clog2(NREG).
- INSTR_LEN, 32, instruction width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction_in is valid.
- in_ready  out  1  stage accepts instruction_in this cycle.
- instruction_in  in  INSTR_LEN  fetched instruction.
- wr_en  in  1  write-back enable.
- wr_addr  in  clog2(NREG)  write-back register.
- wr_data  in  WORD  write-back data.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the output this cycle.
- reg2_loc, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, uncondbranch, illegal  out  1 each  registered control.
- alu_op  out  2  registered ALU op class.
- read_register1, read_register2, write_register  out  clog2(NREG) each  registered register indices.
- read_data1, read_data2, sign_extended_output  out  WORD each  registered operands.

Behaviour:
- Reset (async assert, sync release): all outputs 0, out_valid=0, every register-file entry 0.
- Handshakes:
  - Accept = in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard.
  - The output register loads on accept.
  - If out_valid && out_ready and no accept, out_valid clears.
  - While out_valid && !out_ready, all outputs hold stable.
- Latency: one cycle from accept to out_valid.
- Decode (opcode in [31:21] unless noted):
  - LDUR 7C2: alu_src, mem_read, mem_to_reg, reg_write; alu_op 00.
  - STUR 7C0: reg2_loc, alu_src, mem_write; alu_op 00.
  - ADD 458, SUB 658, AND 450, ORR 550: reg_write; alu_op 10.
  - CBZ ([31:24]=B4): reg2_loc, branch; alu_op 01.
  - B ([31:26]=05): uncondbranch.
  - Anything else: all control 0 and illegal=1; the instruction still flows as valid.
- Register fields:
  - read_register1 = [9:5].
  - read_register2 = reg2_loc ? [4:0] : [20:16].
  - write_register = [4:0].
- Sign extension to WORD:
  - LDUR/STUR: imm9 [20:12].
  - CBZ: imm19 [23:5].
  - B: imm26 [25:0].
  - Otherwise 0.
  - No scaling is applied.
- Register file:
  - Write on the rising edge when wr_en and wr_addr != NREG-1.
  - Reads are combinational; XZR reads 0.
  - A same-cycle read and write of the same register captures the old value unless WB_BYPASS_EN is defined.
- Hazard:
  - Raised when out_valid && mem_read && write_register != XZR, and write_register equals the incoming read_register1, or the incoming read_register2 when the incoming instruction uses it (R-type, STUR, CBZ).
  - While hazard is high: in_ready=0.
  - If out_ready is also high, the output register takes a bubble (out_valid=0). The bubble lasts exactly one cycle, then the dependent instruction is accepted.
  - If out_ready is low, the stage holds.
- Simultaneous write-back and hazard: the write still occurs; the stalled instruction reads the new value on its retry.
- Reset mid-operation: the in-flight instruction is discarded and the register file is cleared.

Optional Feature:
- WB_BYPASS_EN defined: when wr_en && wr_addr equals a read index (and is not XZR), wr_data is forwarded to that read_data in the same cycle.
- Undefined: the old register value is read; the bench must delay the read by one cycle.

Decomposition:
- Shared package/header (alongside WORD/INSTR_LEN definitions) holds:
  - opcode constants (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B);
  - alu_op encodings 00/01/10;
  - the XZR index.
- One sub-module: decode_regfile (NREG x WORD, two read ports, one write port, async reset, optional bypass).
- Control decode and the hazard compare stay inline.

Test Plan:
- Preload X22=100 via the write port, then LDUR X9,[X22,#64] (F84402C9) -> next cycle out_valid=1, read_data1=100, sign_extended_output=64, write_register=9, mem_read=alu_src=mem_to_reg=reg_write=1, alu_op=00.
- LDUR F84402C9 immediately followed by ADD X10,X19,X9 (8B09026A) with out_ready=1 -> in_ready=0 for exactly 1 cycle; one bubble (out_valid=0); ADD then emitted with read_register2=9, alu_op=10.
- CBZ X11,-5 (B4FFFF6B) -> sign_extended_output=FFFF_FFFF_FFFF_FFFB, branch=1, reg2_loc=1, read_register2=11. Then B -55 (17FFFFC9) -> sign_extended_output=...FFC9, uncondbranch=1.
- ORR X9,X10,X21 (AA150149) accepted, then out_ready=0 for 3 cycles -> all outputs stable, in_ready=0; the next instruction is accepted only after out_ready=1.
- Write X31=77, then read XZR as a source -> read_data=0.
- Same-cycle wr_en X10=30 with a read of X10 -> 30 if WB_BYPASS_EN, else old value 0.
- Assert rst_n=0 mid-stream -> out_valid=0 immediately, and X22 subsequently reads 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the LEGv8 decode stage: widths, opcodes, ALU op
// classes, the XZR index and the instruction classifier.
package decode_stage_pkg;

    localparam int WORD_W   = 64;
    localparam int INSTR_W  = 32;
    localparam int NREG_DEF = 32;
    localparam int XZR_IDX  = NREG_DEF - 1;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_LDUR,
        CLS_STUR,
        CLS_RTYPE,
        CLS_CBZ,
        CLS_B
    } instr_cls_e;

    typedef struct packed {
        logic       reg2_loc;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       uncondbranch;
        logic       illegal;
        logic [1:0] alu_op;
    } ctrl_t;

    // Opcode fields have different widths per format; the wider ones win first.
    function automatic instr_cls_e classify(input logic [31:0] instr);
        instr_cls_e cls;
        cls = CLS_ILLEGAL;
        if (instr[31:21] == OP_LDUR) begin
            cls = CLS_LDUR;
        end else if (instr[31:21] == OP_STUR) begin
            cls = CLS_STUR;
        end else if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
                     instr[31:21] == OP_AND || instr[31:21] == OP_ORR) begin
            cls = CLS_RTYPE;
        end else if (instr[31:24] == OP_CBZ) begin
            cls = CLS_CBZ;
        end else if (instr[31:26] == OP_B) begin
            cls = CLS_B;
        end
        return cls;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREG x WORD register file, two combinational read ports, one write port.
// Top index is XZR. Define WB_BYPASS_EN to forward same-cycle write data.
module decode_regfile #(
    parameter int WORD = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd_addr1_i,
    input  logic [AW-1:0]   rd_addr2_i,
    output logic [WORD-1:0] rd_data1_o,
    output logic [WORD-1:0] rd_data2_o,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [WORD-1:0] wr_data_i
);

    localparam logic [AW-1:0] XZR = AW'(NREG - 1);

    logic [WORD-1:0] regs_q [NREG];
    logic            wr_ok;

    assign wr_ok = wr_en_i && (wr_addr_i != XZR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data1_o = (rd_addr1_i == XZR) ? '0 : regs_q[rd_addr1_i];
        rd_data2_o = (rd_addr2_i == XZR) ? '0 : regs_q[rd_addr2_i];
`ifdef WB_BYPASS_EN
        // wr_ok already excludes XZR, so a forwarded value is never nonzero XZR.
        if (wr_ok && (wr_addr_i == rd_addr1_i)) begin
            rd_data1_o = wr_data_i;
        end
        if (wr_ok && (wr_addr_i == rd_addr2_i)) begin
            rd_data2_o = wr_data_i;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// LEGv8 pipelined decode stage: control decode, register read, immediate
// sign extension and load-use bubble, registered into ID/EX. Optional WB_BYPASS_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WORD      = WORD_W,
    parameter int NREG      = NREG_DEF,
    parameter int INSTR_LEN = INSTR_W,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_LEN-1:0] instruction_in,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WORD-1:0]      wr_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 reg2_loc,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic                 uncondbranch,
    output logic                 illegal,
    output logic [1:0]           alu_op,
    output logic [AW-1:0]        read_register1,
    output logic [AW-1:0]        read_register2,
    output logic [AW-1:0]        write_register,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2,
    output logic [WORD-1:0]      sign_extended_output
);

    localparam logic [AW-1:0] XZR = AW'(NREG - 1);

    logic [31:0]     instr;
    instr_cls_e      cls;
    ctrl_t           ctrl_d;
    logic [WORD-1:0] imm_d;
    logic            uses_rs2;
    logic [AW-1:0]   rr1_d;
    logic [AW-1:0]   rr2_d;
    logic [AW-1:0]   wreg_d;
    logic [WORD-1:0] rd1_d;
    logic [WORD-1:0] rd2_d;

    logic            out_valid_q;
    logic            out_valid_d;
    ctrl_t           ctrl_q;
    logic [AW-1:0]   rr1_q;
    logic [AW-1:0]   rr2_q;
    logic [AW-1:0]   wreg_q;
    logic [WORD-1:0] rd1_q;
    logic [WORD-1:0] rd2_q;
    logic [WORD-1:0] imm_q;

    logic            load_pending;
    logic            hazard;
    logic            accept;

    assign instr = instruction_in[31:0];
    assign cls   = classify(instr);

    always_comb begin
        ctrl_d   = '0;
        imm_d    = '0;
        uses_rs2 = 1'b0;
        case (cls)
            CLS_LDUR: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_op     = ALU_OP_MEM;
                imm_d             = {{(WORD-9){instr[20]}}, instr[20:12]};
            end
            CLS_STUR: begin
                ctrl_d.reg2_loc   = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_write  = 1'b1;
                ctrl_d.alu_op     = ALU_OP_MEM;
                imm_d             = {{(WORD-9){instr[20]}}, instr[20:12]};
                uses_rs2          = 1'b1;
            end
            CLS_RTYPE: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_op     = ALU_OP_RTYPE;
                uses_rs2          = 1'b1;
            end
            CLS_CBZ: begin
                ctrl_d.reg2_loc   = 1'b1;
                ctrl_d.branch     = 1'b1;
                ctrl_d.alu_op     = ALU_OP_BRANCH;
                imm_d             = {{(WORD-19){instr[23]}}, instr[23:5]};
                uses_rs2          = 1'b1;
            end
            CLS_B: begin
                ctrl_d.uncondbranch = 1'b1;
                imm_d               = {{(WORD-26){instr[25]}}, instr[25:0]};
            end
            default: begin
                ctrl_d.illegal = 1'b1;
            end
        endcase
    end

    assign rr1_d  = AW'(instr[9:5]);
    assign rr2_d  = ctrl_d.reg2_loc ? AW'(instr[4:0]) : AW'(instr[20:16]);
    assign wreg_d = AW'(instr[4:0]);

    decode_regfile #(
        .WORD (WORD),
        .NREG (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr1_i (rr1_d),
        .rd_addr2_i (rr2_d),
        .rd_data1_o (rd1_d),
        .rd_data2_o (rd2_d),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data)
    );

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at the rising edge. in_ready depends on out_ready and the hazard
    // compare only, never on in_valid of the same side, except that a hazard is
    // raised only against a presented instruction.
    assign load_pending = out_valid_q && ctrl_q.mem_read && (wreg_q != XZR);
    assign hazard       = in_valid && load_pending &&
                          ((wreg_q == rr1_d) || (uses_rs2 && (wreg_q == rr2_d)));
    assign in_ready     = (!out_valid_q || out_ready) && !hazard;
    assign accept       = in_valid && in_ready;

    // A hazard with out_ready high drains the load without refilling: the bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rr1_q       <= '0;
            rr2_q       <= '0;
            wreg_q      <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                ctrl_q <= ctrl_d;
                rr1_q  <= rr1_d;
                rr2_q  <= rr2_d;
                wreg_q <= wreg_d;
                rd1_q  <= rd1_d;
                rd2_q  <= rd2_d;
                imm_q  <= imm_d;
            end
        end
    end

    assign out_valid            = out_valid_q;
    assign reg2_loc             = ctrl_q.reg2_loc;
    assign branch               = ctrl_q.branch;
    assign mem_read             = ctrl_q.mem_read;
    assign mem_to_reg           = ctrl_q.mem_to_reg;
    assign mem_write            = ctrl_q.mem_write;
    assign alu_src              = ctrl_q.alu_src;
    assign reg_write            = ctrl_q.reg_write;
    assign uncondbranch         = ctrl_q.uncondbranch;
    assign illegal              = ctrl_q.illegal;
    assign alu_op               = ctrl_q.alu_op;
    assign read_register1       = rr1_q;
    assign read_register2       = rr2_q;
    assign write_register       = wreg_q;
    assign read_data1           = rd1_q;
    assign read_data2           = rd2_q;
    assign sign_extended_output = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, hand sequences for
// hazard/hold/reset corners, and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam int WORD = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [8:0] C_LDUR = 9'b001101100;
  localparam logic [8:0] C_STUR = 9'b100011000;
  localparam logic [8:0] C_RTYP = 9'b000000100;
  localparam logic [8:0] C_CBZ  = 9'b110000000;
  localparam logic [8:0] C_B    = 9'b000000010;
  localparam logic [8:0] C_ILL  = 9'b000000001;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction_in;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [WORD-1:0] wr_data;
  logic            out_valid;
  logic            out_ready;
  logic            reg2_loc, branch, mem_read, mem_to_reg, mem_write;
  logic            alu_src, reg_write, uncondbranch, illegal;
  logic [1:0]      alu_op;
  logic [AW-1:0]   read_register1, read_register2, write_register;
  logic [WORD-1:0] read_data1, read_data2, sign_extended_output;
  logic [8:0]      got_ctrl;

  always #5 clk = ~clk;

  assign got_ctrl = {reg2_loc, branch, mem_read, mem_to_reg, mem_write,
                     alu_src, reg_write, uncondbranch, illegal};

  decode_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .instruction_in       (instruction_in),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .reg2_loc             (reg2_loc),
    .branch               (branch),
    .mem_read             (mem_read),
    .mem_to_reg           (mem_to_reg),
    .mem_write            (mem_write),
    .alu_src              (alu_src),
    .reg_write            (reg_write),
    .uncondbranch         (uncondbranch),
    .illegal              (illegal),
    .alu_op               (alu_op),
    .read_register1       (read_register1),
    .read_register2       (read_register2),
    .write_register       (write_register),
    .read_data1           (read_data1),
    .read_data2           (read_data2),
    .sign_extended_output (sign_extended_output)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [8:0]  ctrl;
    logic [1:0]  alu_op;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [63:0] imm;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        uses_rs2;
  } exp_t;

  logic [63:0] ref_regs [NREG];
  logic        m_valid;
  exp_t        m_rec;
  logic        ready_seen;

  function automatic longint sext(input longint v, input int n);
    longint half;
    half = longint'(1) << (n - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] ins);
    exp_t   e;
    int     op11;
    longint imm;
    e    = '0;
    op11 = int'(ins[31:21]);
    imm  = 0;
    e.rr1 = ins[9:5];
    e.wr  = ins[4:0];
    if (op11 == 'h7C2) begin
      e.ctrl = C_LDUR; imm = sext(longint'(ins[20:12]), 9);
    end else if (op11 == 'h7C0) begin
      e.ctrl = C_STUR; imm = sext(longint'(ins[20:12]), 9); e.uses_rs2 = 1'b1;
    end else if (op11 == 'h458 || op11 == 'h658 || op11 == 'h450 || op11 == 'h550) begin
      e.ctrl = C_RTYP; e.alu_op = 2'b10; e.uses_rs2 = 1'b1;
    end else if (ins[31:24] == 8'hB4) begin
      e.ctrl = C_CBZ; e.alu_op = 2'b01; imm = sext(longint'(ins[23:5]), 19); e.uses_rs2 = 1'b1;
    end else if (ins[31:26] == 6'h05) begin
      e.ctrl = C_B; imm = sext(longint'(ins[25:0]), 26);
    end else begin
      e.ctrl = C_ILL;
    end
    e.rr2 = e.ctrl[8] ? ins[4:0] : ins[20:16];
    e.imm = 64'(imm);
    return e;
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] idx, input logic wen,
                                           input logic [4:0] waddr, input logic [63:0] wdata);
    if (idx == 5'd31) return 64'd0;
`ifdef WB_BYPASS_EN
    if (wen && waddr == idx) return wdata;
`endif
    return ref_regs[idx];
  endfunction

  task automatic check_out();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("ctrl", 64'(got_ctrl), 64'(m_rec.ctrl));
      chk("alu_op", 64'(alu_op), 64'(m_rec.alu_op));
      chk("read_register1", 64'(read_register1), 64'(m_rec.rr1));
      chk("read_register2", 64'(read_register2), 64'(m_rec.rr2));
      chk("write_register", 64'(write_register), 64'(m_rec.wr));
      chk("read_data1", read_data1, m_rec.rd1);
      chk("read_data2", read_data2, m_rec.rd2);
      chk("sign_ext", sign_extended_output, m_rec.imm);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic cycle();
    exp_t d;
    logic haz;
    logic exp_rdy;
    #1;
    d   = ref_dec(instruction_in);
    haz = in_valid && m_valid && m_rec.ctrl[6] && (m_rec.wr != 5'd31) &&
          ((m_rec.wr == d.rr1) || (d.uses_rs2 && (m_rec.wr == d.rr2)));
    exp_rdy    = (!m_valid || out_ready) && !haz;
    ready_seen = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (in_valid && exp_rdy) begin
      d.rd1   = ref_read(d.rr1, wr_en, wr_addr, wr_data);
      d.rd2   = ref_read(d.rr2, wr_en, wr_addr, wr_data);
      m_rec   = d;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wr_en && wr_addr != 5'd31) ref_regs[wr_addr] = wr_data;
    @(negedge clk);
    check_out();
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] v);
    in_valid = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = v;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1; instruction_in = ins; out_ready = 1'b1;
    cycle();
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) ref_regs[i] = 64'd0;
    m_valid = 1'b0;
    m_rec   = '0;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = pick_reg(); b = pick_reg(); c = pick_reg();
    case ($urandom_range(0, 8))
      0:       return {11'h7C2, 9'($urandom), 2'b00, a, b};
      1:       return {11'h7C0, 9'($urandom), 2'b00, a, b};
      2:       return {11'h458, c, 6'($urandom), a, b};
      3:       return {11'h658, c, 6'($urandom), a, b};
      4:       return {11'h450, c, 6'($urandom), a, b};
      5:       return {11'h550, c, 6'($urandom), a, b};
      6:       return {8'hB4, 14'($urandom), a, b};
      7:       return {6'h05, 26'($urandom)};
      default: return {11'h000, 21'($urandom)};
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [8:0]  ctrl;
    logic [1:0]  alu_op;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [63:0] imm;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{32'hF84402C9, C_LDUR, 2'b00, 5'd22, 5'd4,  5'd9,  64'd64};
    vecs[1] = '{32'hF81F8083, C_STUR, 2'b00, 5'd4,  5'd3,  5'd3,  64'hFFFF_FFFF_FFFF_FFF8};
    vecs[2] = '{32'h8B09026A, C_RTYP, 2'b10, 5'd19, 5'd9,  5'd10, 64'd0};
    vecs[3] = '{32'hCB020064, C_RTYP, 2'b10, 5'd3,  5'd2,  5'd4,  64'd0};
    vecs[4] = '{32'h8A0500C7, C_RTYP, 2'b10, 5'd6,  5'd5,  5'd7,  64'd0};
    vecs[5] = '{32'hAA150149, C_RTYP, 2'b10, 5'd10, 5'd21, 5'd9,  64'd0};
    vecs[6] = '{32'hB4FFFF6B, C_CBZ,  2'b01, 5'd27, 5'd11, 5'd11, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[7] = '{32'h17FFFFC9, C_B,    2'b00, 5'd30, 5'd31, 5'd9,  64'hFFFF_FFFF_FFFF_FFC9};
    vecs[8] = '{32'h00000000, C_ILL,  2'b00, 5'd0,  5'd0,  5'd0,  64'd0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instruction_in = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; ready_seen = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl", 64'({got_ctrl, alu_op}), 64'd0);
    chk("rst_regs", 64'({read_register1, read_register2, write_register}), 64'd0);
    chk("rst_rd1", read_data1, 64'd0);
    chk("rst_imm", sign_extended_output, 64'd0);

    // preload and first LDUR
    wb(5'd22, 64'd100);
    wb(5'd19, 64'd5);
    issue(32'hF84402C9);
    chk("ldur_valid", 64'(out_valid), 64'd1);
    chk("ldur_rd1", read_data1, 64'd100);
    chk("ldur_imm", sign_extended_output, 64'd64);
    chk("ldur_wr", 64'(write_register), 64'd9);
    chk("ldur_ctrl", 64'(got_ctrl), 64'(C_LDUR));

    // load-use: dependent ADD stalls one cycle, bubble, then issues
    instruction_in = 32'h8B09026A;
    cycle();
    chk("hz_stall_ready", 64'(ready_seen), 64'd0);
    chk("hz_bubble", 64'(out_valid), 64'd0);
    cycle();
    chk("hz_retry_ready", 64'(ready_seen), 64'd1);
    chk("hz_add_valid", 64'(out_valid), 64'd1);
    chk("hz_add_rr2", 64'(read_register2), 64'd9);
    chk("hz_add_aluop", 64'(alu_op), 64'b10);
    chk("hz_add_rd1", read_data1, 64'd5);
    drain();

    // table of single instructions
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].instr);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_ctrl", i), 64'(got_ctrl), 64'(vecs[i].ctrl));
      chk($sformatf("tbl%0d_aluop", i), 64'(alu_op), 64'(vecs[i].alu_op));
      chk($sformatf("tbl%0d_rr1", i), 64'(read_register1), 64'(vecs[i].rr1));
      chk($sformatf("tbl%0d_rr2", i), 64'(read_register2), 64'(vecs[i].rr2));
      chk($sformatf("tbl%0d_wr", i), 64'(write_register), 64'(vecs[i].wr));
      chk($sformatf("tbl%0d_imm", i), sign_extended_output, vecs[i].imm);
      drain();
    end

    // write-back during a load-use stall is seen on retry
    issue(32'hF84402C9);
    instruction_in = 32'h8B09026A;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd55;
    cycle();
    chk("wbhz_stall", 64'(ready_seen), 64'd0);
    wr_en = 1'b0;
    cycle();
    chk("wbhz_rd2", read_data2, 64'd55);
    drain();

    // hold while out_ready low
    issue(32'hAA150149);
    instruction_in = 32'hCB020064;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_ready", 64'(ready_seen), 64'd0);
      chk("hold_wr", 64'(write_register), 64'd9);
      chk("hold_rr2", 64'(read_register2), 64'd21);
    end
    out_ready = 1'b1;
    cycle();
    chk("hold_release_ready", 64'(ready_seen), 64'd1);
    chk("hold_next_wr", 64'(write_register), 64'd4);
    drain();

    // XZR writes ignored, reads zero
    wb(5'd31, 64'd77);
    issue(32'h8B1F03E1);
    chk("xzr_rd1", read_data1, 64'd0);
    chk("xzr_rd2", read_data2, 64'd0);
    drain();

    // same-cycle write and read of X10
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'd30;
    issue(32'hAA150149);
    wr_en = 1'b0;
`ifdef WB_BYPASS_EN
    chk("samecyc_rd1", read_data1, 64'd30);
`else
    chk("samecyc_rd1", read_data1, 64'd0);
`endif
    issue(32'hAA150149);
    chk("nextcyc_rd1", read_data1, 64'd30);
    drain();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      instruction_in = rand_instr();
      wr_en          = ($urandom_range(0, 2) == 0);
      wr_addr        = pick_reg();
      wr_data        = {$urandom, $urandom};
      cycle();
    end
    wr_en = 1'b0;
    drain();

    // reset in the middle of traffic
    wb(5'd22, 64'd100);
    in_valid = 1'b1; instruction_in = 32'hAA150149; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'hF84402C9);
    chk("midrst_x22", read_data1, 64'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
